// File: rtl/alu_rs_dispatch.sv
// alu_rs_dispatch: steers up to two in-order decoded ALU instructions per cycle
// into the two ALU reservation-station slots.
//
// Optional build macro: ALU_ALLOC_STAT_EN enables the saturating stall counter.
// Without it, stall_cnt is tied to zero.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-low (0 = reset)
//   rdy        global ready; 0 freezes all state and blocks grants
//   flush      branch-mispredict flush; frees both slots, drops the en pulse
//   req_valid  per-lane valid, bit0 = older lane
//   req_data0  lane0 payload
//   req_data1  lane1 payload
//   req_ready  per-lane accept (combinational)
//   slot_busy  next-busy feedback from the station, per slot
//   en         registered slot write enables (one-cycle pulse per grant)
//   out_data0  registered payload for slot0 (holds when en[0]=0)
//   out_data1  registered payload for slot1 (holds when en[1]=0)
//   free_cnt   number of FREE slots (0..2)
//   stall_cnt  cycles where lane0 was valid but could not be accepted
module alu_rs_dispatch #(
    parameter int unsigned PAYLOAD_W = 138,
    parameter int unsigned STAT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic [1:0]           req_valid,
    input  logic [PAYLOAD_W-1:0] req_data0,
    input  logic [PAYLOAD_W-1:0] req_data1,
    output logic [1:0]           req_ready,
    input  logic [1:0]           slot_busy,
    output logic [1:0]           en,
    output logic [PAYLOAD_W-1:0] out_data0,
    output logic [PAYLOAD_W-1:0] out_data1,
    output logic [1:0]           free_cnt,
    output logic [STAT_W-1:0]    stall_cnt
);

    localparam int unsigned NUM_SLOTS = 2;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_BUSY = 2'd2
    } slot_state_e;

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_d [NUM_SLOTS];
    logic                 rr_q, rr_d;
    logic [1:0]           en_q, en_d;
    logic [PAYLOAD_W-1:0] data0_q, data0_d;
    logic [PAYLOAD_W-1:0] data1_q, data1_d;

    logic [1:0] free;
    logic       both_free;
    logic       any_free;
    logic       active;
    logic       acc0;
    logic       acc1;
    logic       lane0_slot;
    logic [1:0] grant;

    // Accept and slot-steering decode from the registered slot states
    always_comb begin
        free[0]    = (state_q[0] == SLOT_FREE);
        free[1]    = (state_q[1] == SLOT_FREE);
        both_free  = &free;
        any_free   = |free;
        active     = rst & rdy & ~flush;
        acc0       = active & req_valid[0] & any_free;
        acc1       = acc0 & req_valid[1] & both_free;
        // With both free lane0 follows rr; otherwise it takes the lone free slot
        lane0_slot = both_free ? rr_q : free[1];
        grant      = 2'b00;
        if (acc0) begin
            grant[lane0_slot] = 1'b1;
        end
        if (acc1) begin
            grant[~lane0_slot] = 1'b1;
        end
    end

    assign req_ready = {acc1, acc0};
    assign free_cnt  = 2'(free[0]) + 2'(free[1]);

    // Next-state for slot FSMs, round-robin pointer, enables and payloads
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        en_d    = en_q;
        data0_d = data0_q;
        data1_d = data1_q;

        if (rdy) begin
            if (flush) begin
                state_d[0] = SLOT_FREE;
                state_d[1] = SLOT_FREE;
                en_d       = 2'b00;
            end else begin
                en_d = grant;
                for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                    unique case (state_q[s])
                        SLOT_FREE: if (grant[s])      state_d[s] = SLOT_PEND;
                        // PEND covers the station's feedback latency
                        SLOT_PEND:                    state_d[s] = SLOT_BUSY;
                        SLOT_BUSY: if (!slot_busy[s]) state_d[s] = SLOT_FREE;
                        default:                      state_d[s] = SLOT_FREE;
                    endcase
                end
                // Only a single grant into two free slots advances the pointer
                if (acc0 && !acc1 && both_free) begin
                    rr_d = ~rr_q;
                end
                // A slot receives lane1 only when lane0 went to the other slot
                if (grant[0]) begin
                    data0_d = (acc1 && lane0_slot) ? req_data1 : req_data0;
                end
                if (grant[1]) begin
                    data1_d = (acc1 && !lane0_slot) ? req_data1 : req_data0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q[0] <= SLOT_FREE;
            state_q[1] <= SLOT_FREE;
            rr_q       <= 1'b0;
            en_q       <= 2'b00;
            data0_q    <= '0;
            data1_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            en_q    <= en_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign en        = en_q;
    assign out_data0 = data0_q;
    assign out_data1 = data1_q;

`ifdef ALU_ALLOC_STAT_EN
    logic [STAT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles where the oldest lane was refused
    always_comb begin
        stall_d = stall_q;
        if (rdy && !flush && req_valid[0] && !acc0 && (stall_q != '1)) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
